fetch_unit: RTL

Program-counter / fetch sequencer for the 9-bit single-cycle core. Consumes the per-instruction control decode (jump, branch, flag write, halt) and the ALU comparison flag. Holds the architectural PC and the condition flag, and sequences a Start/Done program run. Its `pc` output addresses the instruction ROM; the decoded instruction returns combinationally in the same cycle.

---
 rtl/fetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// PC / fetch sequencer for the 9-bit core: holds the PC and condition flag and runs the IDLE/RUN/DONE program sequence.
// Optional RUN-cycle counter and cycle_count port are enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            jump_en,
  input  logic            branch_en,
  input  logic            flag_write,
  input  logic            flag_in,
  input  logic            halt,
  input  logic [PC_W-1:0] target,
  input  logic [7:0]      offset,
  output logic [PC_W-1:0] pc,
  output logic            flag_q,
  output logic            running,
  output logic            Done
`ifdef FETCH_CYCLE_CNT_EN
  ,
  output logic [15:0]     cycle_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            flag_nxt;
  logic [PC_W-1:0] off_ext;

  // Signed cast sign-extends the displacement; the add then wraps modulo 2^PC_W.
  assign off_ext = PC_W'($signed(offset));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      pc     <= START_ADDR;
      flag_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      flag_q <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    flag_nxt  = flag_q;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          flag_nxt  = 1'b0;
        end
      end
      RUN: begin
        // Branch tests the pre-edge flag, so a same-cycle compare is not seen.
        if (flag_write) flag_nxt = flag_in;
        if (halt)                       state_nxt = DONE;
        else if (jump_en)               pc_nxt = target;
        else if (branch_en && flag_q)   pc_nxt = pc + off_ext;
        else                            pc_nxt = pc + PC_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign Done    = (state == DONE);

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cycle_count <= 16'd0;
    end else if (state != RUN) begin
      if (Start) cycle_count <= 16'd0;
    end else if (cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule
